alu_mode_sequencer: RTL
=======================

Name: alu_mode_sequencer

Overview:
- Controller that sweeps the 4-bit ALU/seven-segment datapath through all 16 `mode_d` operations for one operand set.
- Holds each mode for a settle window, captures `{c_out, result}` into a 16-entry result file, and exposes a registered readback port.
- Sits between the operand/switch source and the ALU in `system`. Drives `mode_d`, `mode_ss`, `a`, `b` and `c_in`. Supports free-run and single-step sweeps.

Parameters:
- W, 4, operand/result width.
- SETTLE_CYCLES, 2, cycles each mode is held before capture (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE/DONE.
- step_en  in  1  1 = pause after each capture until `step`.
- step  in  1  advance one mode while in WAIT_STEP.
- op_a  in  W  operand A; latched at start.
- op_b  in  W  operand B; latched at start.
- op_cin  in  1  carry-in; latched at start.
- alu_result  in  W  ALU result for the current mode.
- alu_cout  in  1  ALU carry-out.
- mode_d  out  4  ALU operation select.
- mode_ss  out  1  equals mode_d[3], registered together with mode_d.
- alu_a  out  W  operand A driven to the ALU.
- alu_b  out  W  operand B driven to the ALU.
- alu_cin  out  1  carry-in driven to the ALU.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next start or rst.
- rd_addr  in  4  result-file read address.
- rd_data  out  W+1  `{cout, result}` of entry `rd_addr`; 1-cycle latency.

Behaviour:
- Reset (rst=1 at a clk edge) takes effect at that edge, including mid-sweep:
  - state = IDLE.
  - mode_d, mode_ss, alu_a, alu_b, alu_cin, busy, done, rd_data all = 0.
  - All 16 result entries cleared to 0.
- States: IDLE, SETTLE, WAIT_STEP, DONE. DONE behaves as IDLE but with done=1.
- IDLE/DONE with start=1 sampled at edge T. From T+1:
  - alu_a/alu_b/alu_cin = op_a/op_b/op_cin.
  - mode_d = 0, busy = 1, done = 0, settle counter = 0, state = SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - On the edge ending the SETTLE_CYCLES-th cycle of the current mode: `mem[mode_d] <= {alu_cout, alu_result}`.
  - Same edge, next step decided in this order:
    - mode_d == 15: state = DONE, busy = 0, done = 1. mode_d and operands hold their last values.
    - else step_en == 1 (sampled at that edge): state = WAIT_STEP, mode_d holds.
    - else mode_d += 1, counter = 0, stay in SETTLE.
- WAIT_STEP: mode_d holds. On step=1: mode_d += 1, counter = 0, state = SETTLE.
- Free-run sweep timing: busy high for exactly 16*SETTLE_CYCLES cycles; done rises the cycle busy falls.
- Ignored inputs:
  - start while busy.
  - step outside WAIT_STEP.
  - op_a/op_b/op_cin changes after the start edge.
- rd_data:
  - Registered read: rd_data at T+1 = mem[rd_addr at T]. Valid in every state.
  - Read and capture to the same entry at the same edge returns the old value; the new value appears on the following read.
- mode_d never wraps past 15. A new sweep always restarts at 0.

Test Plan:
- Reset: assert rst 2 cycles mid-sweep (mode_d = 5) -> next cycle busy=0, done=0, mode_d=0, mode_ss=0, alu_a=0; reads of addr 0..15 return 0.
- Free run, SETTLE_CYCLES=2. Stimulus: op_a=6, op_b=3, op_cin=0, step_en=0, start pulse. ALU stub computes `{cout, res} = a + b + cin + mode_d`. Required:
  - mode_d steps 0..15, each held 2 cycles.
  - mode_ss=0 for modes 0-7, 1 for modes 8-15.
  - busy high 32 cycles, then done=1.
  - Readback: addr0 -> 5'b0_1001, addr6 -> 5'b0_1111, addr7 -> 5'b1_0000, addr15 -> 5'b1_1000.
- Single step, step_en=1:
  - After mode-0 capture, mode_d stays 0 and busy stays 1 for 10 idle cycles.
  - One-cycle step pulse -> mode_d=1 on the next cycle.
  - 15 steps total -> done=1.
- Ignored inputs during a sweep: start pulse at mode 3 and op_a changed to 4'hF at mode 4 -> no restart; alu_a stays 6; captured entries match the op_a=6 values.
- Re-run from DONE: start with op_a=1, op_b=1, op_cin=1 -> done drops next cycle, mode_d=0, alu_cin=1; addr0 reads 5'b0_0011 after the sweep.
- Read/write collision: rd_addr=4 held during mode-4 capture -> rd_data shows the old value (0 on the first sweep) at the capture edge and 5'b0_1101 one cycle later.

Source files
------------

// File: rtl/alu_mode_sequencer.sv
// Purpose: sweeps a 4-bit ALU through all 16 operation modes for one latched
// operand set, holds each mode for a settle window, captures {cout, result}
// into a 16-entry result file and offers a registered readback port.
// Supports free-run sweeps and single-step sweeps.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a sweep (honoured only when idle or done)
//   step_en, step       pause after each capture / advance one mode
//   op_a, op_b, op_cin  operands latched at start
//   alu_result, alu_cout  ALU response for the current mode
//   mode_d, mode_ss     ALU operation select and its MSB (registered together)
//   alu_a, alu_b, alu_cin  operands driven to the ALU
//   busy, done          sweep in progress / sweep complete (sticky)
//   rd_addr, rd_data    result-file read, 1-cycle latency
module alu_mode_sequencer #(
  parameter int unsigned W             = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step_en,
  input  logic         step,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout,
  output logic [3:0]   mode_d,
  output logic         mode_ss,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_cin,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [W:0]   rd_data
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MODE_W  = 4;
  localparam int unsigned ENTRIES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT_STEP,
    DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [MODE_W-1:0]   mode_nxt;
  logic [W-1:0]        a_nxt;
  logic [W-1:0]        b_nxt;
  logic                cin_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                cap_en_c;
  logic [W:0]          mem [ENTRIES];

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_nxt  = cnt_q;
    mode_nxt = mode_d;
    a_nxt    = alu_a;
    b_nxt    = alu_b;
    cin_nxt  = alu_cin;
    busy_nxt = busy;
    done_nxt = done;
    cap_en_c = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_nxt    = op_a;
          b_nxt    = op_b;
          cin_nxt  = op_cin;
          mode_nxt = '0;
          cnt_nxt  = '0;
          busy_nxt = 1'b1;
          done_nxt = 1'b0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        // Last cycle of the settle window: capture, then decide where to go.
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cap_en_c = 1'b1;
          if (mode_d == MODE_W'(ENTRIES - 1)) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
            state_d  = DONE;
          end else if (step_en) begin
            state_d = WAIT_STEP;
          end else begin
            mode_nxt = mode_d + MODE_W'(1);
            cnt_nxt  = '0;
          end
        end
      end
      WAIT_STEP: begin
        if (step) begin
          mode_nxt = mode_d + MODE_W'(1);
          cnt_nxt  = '0;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_d  <= '0;
      mode_ss <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_nxt;
      mode_d  <= mode_nxt;
      mode_ss <= mode_nxt[MODE_W-1];
      alu_a   <= a_nxt;
      alu_b   <= b_nxt;
      alu_cin <= cin_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Result file; a read colliding with a capture returns the pre-capture value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (cap_en_c) begin
        mem[mode_d] <= {alu_cout, alu_result};
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule
